// File: rtl/elixirchip_es1_spu_flag_run_pkg.sv
// Shared helpers for the SPU flag run counter: saturation limit and
// compare width so the threshold test never wraps.
package elixirchip_es1_spu_flag_run_pkg;

    // The threshold compare runs one bit wider than the counter.
    localparam int CMP_EXTRA_BITS = 1;

    function automatic int cmp_width(input int count_bits);
        return count_bits + CMP_EXTRA_BITS;
    endfunction

    // Largest count a COUNT_BITS-wide run counter can hold (up to 32 bits).
    function automatic logic [32:0] sat_limit(input int count_bits);
        return (33'd1 << count_bits) - 33'd1;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_flag_run_delay.sv
// Generic cke-gated shift pipeline, async active-low reset.
// Ports: reset, clk, cke, s_data[WIDTH] -> m_data[WIDTH] after LATENCY cycles.
module elixirchip_es1_spu_flag_run_delay #(
    parameter int    LATENCY = 1,
    parameter int    WIDTH   = 1,
    parameter string DEVICE  = "RTL"
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             cke,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] m_data
);

    if (LATENCY == 0) begin : g_pass
        assign m_data = s_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [LATENCY];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < LATENCY; i++) begin
                    pipe[i] <= '0;
                end
            end else if (cke) begin
                pipe[0] <= s_data;
                for (int i = 1; i < LATENCY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign m_data = pipe[LATENCY-1];
    end

endmodule

// File: rtl/elixirchip_es1_spu_flag_run_counter.sv
// Counts consecutive true SPU condition flags, flags a threshold hit and,
// with ELIXIRCHIP_ES1_SPU_FLAG_RUN_MAX_EN defined, tracks the longest run.
// Ports: reset (async, active-low), clk, cke, s_flag/s_clear/s_valid in;
// m_count, m_hit, m_max_run, m_valid out after LATENCY cke-enabled cycles.
module elixirchip_es1_spu_flag_run_counter
    import elixirchip_es1_spu_flag_run_pkg::*;
#(
    parameter int          LATENCY    = 1,
    parameter int          COUNT_BITS = 8,
    parameter int unsigned THRESHOLD  = 4,
    parameter string       DEVICE     = "RTL",
    parameter string       SIMULATION = "false",
    parameter string       DEBUG      = "false"
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  s_flag,
    input  logic                  s_clear,
    input  logic                  s_valid,
    output logic [COUNT_BITS-1:0] m_count,
    output logic                  m_hit,
    output logic [COUNT_BITS-1:0] m_max_run,
    output logic                  m_valid
);

    localparam int                    CW        = cmp_width(COUNT_BITS);
    localparam logic [32:0]           LIMIT     = sat_limit(COUNT_BITS);
    localparam logic [COUNT_BITS-1:0] RUN_MAX   = LIMIT[COUNT_BITS-1:0];
    // A threshold above the largest count can never be reached.
    localparam bit                    THR_REACH = (33'(THRESHOLD) <= LIMIT);
    localparam logic [CW-1:0]         THR_CMP   = CW'(THRESHOLD);

    logic [COUNT_BITS-1:0] run_q;
    logic [COUNT_BITS-1:0] run_n;
    logic                  hit_n;

    // Without a valid input the held run is presented again.
    always_comb begin
        run_n = run_q;
        if (s_valid) begin
            if (s_clear) begin
                run_n = '0;
            end else if (s_flag) begin
                run_n = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            end else begin
                run_n = '0;
            end
        end
    end

    assign hit_n = THR_REACH && ({1'b0, run_n} >= THR_CMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else if (cke) begin
            run_q <= run_n;
        end
    end

`ifdef ELIXIRCHIP_ES1_SPU_FLAG_RUN_MAX_EN
    localparam int SW = 2 * COUNT_BITS + 2;

    logic [COUNT_BITS-1:0] max_q;
    logic [COUNT_BITS-1:0] max_n;

    always_comb begin
        max_n = max_q;
        if (s_valid) begin
            if (s_clear) begin
                max_n = '0;
            end else if (run_n > max_q) begin
                max_n = run_n;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else if (cke) begin
            max_q <= max_n;
        end
    end

    logic [SW-1:0] stage;
    logic [SW-1:0] dly_out;

    assign stage = {run_n, hit_n, max_n, s_valid};
    assign {m_count, m_hit, m_max_run, m_valid} = dly_out;
`else
    localparam int SW = COUNT_BITS + 2;

    logic [SW-1:0] stage;
    logic [SW-1:0] dly_out;

    assign stage     = {run_n, hit_n, s_valid};
    assign {m_count, m_hit, m_valid} = dly_out;
    assign m_max_run = '0;
`endif

    // Holding the stage at zero during reset keeps the zero-latency build
    // quiet while reset is asserted, matching the registered builds.
    logic [SW-1:0] stage_g;

    assign stage_g = reset ? stage : '0;

    elixirchip_es1_spu_flag_run_delay #(
        .LATENCY (LATENCY),
        .WIDTH   (SW),
        .DEVICE  (DEVICE)
    ) u_delay (
        .reset  (reset),
        .clk    (clk),
        .cke    (cke),
        .s_data (stage_g),
        .m_data (dly_out)
    );

endmodule

// File: tb/tb_elixirchip_es1_spu_flag_run_counter.sv
// Self-checking bench: directed scenarios plus random stream against a
// behavioural run/max model with a latency queue.
module tb_elixirchip_es1_spu_flag_run_counter;

    localparam int LAT_A = 3;
    localparam int CB_A  = 4;
    localparam int THR_A = 3;
    localparam int LIM_A = 15;
    localparam int LAT_B = 0;
    localparam int CB_B  = 8;
    localparam int THR_B = 4;
    localparam int LIM_B = 255;

`ifdef ELIXIRCHIP_ES1_SPU_FLAG_RUN_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cke = 1'b0;
    logic s_flag = 1'b0;
    logic s_clear = 1'b0;
    logic s_valid = 1'b0;

    logic [CB_A-1:0] a_count;
    logic            a_hit;
    logic [CB_A-1:0] a_max;
    logic            a_valid;
    logic [CB_B-1:0] b_count;
    logic            b_hit;
    logic [CB_B-1:0] b_max;
    logic            b_valid;

    always #5 clk = ~clk;

    elixirchip_es1_spu_flag_run_counter #(
        .LATENCY    (LAT_A),
        .COUNT_BITS (CB_A),
        .THRESHOLD  (THR_A)
    ) dut_a (
        .reset     (reset),
        .clk       (clk),
        .cke       (cke),
        .s_flag    (s_flag),
        .s_clear   (s_clear),
        .s_valid   (s_valid),
        .m_count   (a_count),
        .m_hit     (a_hit),
        .m_max_run (a_max),
        .m_valid   (a_valid)
    );

    elixirchip_es1_spu_flag_run_counter #(
        .LATENCY    (LAT_B),
        .COUNT_BITS (CB_B),
        .THRESHOLD  (THR_B)
    ) dut_b (
        .reset     (reset),
        .clk       (clk),
        .cke       (cke),
        .s_flag    (s_flag),
        .s_clear   (s_clear),
        .s_valid   (s_valid),
        .m_count   (b_count),
        .m_hit     (b_hit),
        .m_max_run (b_max),
        .m_valid   (b_valid)
    );

    typedef struct {
        int cnt;
        bit hit;
        int mx;
        bit vld;
    } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_a, max_a, run_b, max_b;
    res_t pipe_a[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model_step(input int run, input int mx,
                                        input int lim, input int thr,
                                        output int nr, output int nm);
        res_t r;
        if (!s_valid)     nr = run;
        else if (s_clear) nr = 0;
        else if (s_flag)  nr = (run < lim) ? run + 1 : lim;
        else              nr = 0;
        if (!s_valid)     nm = mx;
        else if (s_clear) nm = 0;
        else              nm = (nr > mx) ? nr : mx;
        r.cnt = nr;
        r.hit = (nr >= thr);
        r.mx  = MAX_EN ? nm : 0;
        r.vld = s_valid;
        return r;
    endfunction

    task automatic model_reset();
        res_t z;
        z = '{0, 1'b0, 0, 1'b0};
        run_a = 0;
        max_a = 0;
        run_b = 0;
        max_b = 0;
        pipe_a = {};
        repeat (LAT_A) pipe_a.push_back(z);
    endtask

    task automatic cycle(input bit ck, input bit v, input bit f,
                         input bit c);
        res_t ea, eb;
        int   nra, nma, nrb, nmb;
        @(negedge clk);
        cke     = ck;
        s_valid = v;
        s_flag  = f;
        s_clear = c;
        #1;
        ea = model_step(run_a, max_a, LIM_A, THR_A, nra, nma);
        eb = model_step(run_b, max_b, LIM_B, THR_B, nrb, nmb);
        chk("A.count", 64'(a_count), 64'(pipe_a[0].cnt));
        chk("A.hit",   64'(a_hit),   64'(pipe_a[0].hit));
        chk("A.max",   64'(a_max),   64'(pipe_a[0].mx));
        chk("A.valid", 64'(a_valid), 64'(pipe_a[0].vld));
        if (ck) begin
            chk("B.count", 64'(b_count), 64'(eb.cnt));
            chk("B.hit",   64'(b_hit),   64'(eb.hit));
            chk("B.max",   64'(b_max),   64'(eb.mx));
            chk("B.valid", 64'(b_valid), 64'(eb.vld));
        end
        @(posedge clk);
        if (ck) begin
            run_a = nra;
            max_a = nma;
            run_b = nrb;
            max_b = nmb;
            pipe_a.push_back(ea);
            void'(pipe_a.pop_front());
        end
    endtask

    task automatic flush();
        repeat (LAT_A) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a_count", 64'(a_count), 64'd0);
        chk("rst.a_hit",   64'(a_hit),   64'd0);
        chk("rst.a_max",   64'(a_max),   64'd0);
        chk("rst.a_valid", 64'(a_valid), 64'd0);
        chk("rst.b_count", 64'(b_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic run 1,1,1,1,0
        repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        flush();
        chk("s1.max", 64'(a_max), MAX_EN ? 64'd4 : 64'd0);

        // same stream with a cke stall after the second flag
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        flush();

        // saturation
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        flush();
        chk("s3.count", 64'(a_count), 64'd15);
        chk("s3.hit",   64'(a_hit),   64'd1);
        chk("s3.max",   64'(a_max),   MAX_EN ? 64'd15 : 64'd0);

        // clear wins over flag
        repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        flush();
        chk("s4.count", 64'(a_count), 64'd1);
        chk("s4.hit",   64'(a_hit),   64'd0);

        // invalid gap holds the run
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        flush();
        chk("s5.count", 64'(a_count), 64'd3);
        chk("s5.hit",   64'(a_hit),   64'd1);

        // random stream
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        // async reset mid-run
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        s_valid = 1'b0;
        s_flag  = 1'b0;
        reset   = 1'b0;
        #1;
        chk("s6.b_count", 64'(b_count), 64'd0);
        chk("s6.b_hit",   64'(b_hit),   64'd0);
        chk("s6.b_max",   64'(b_max),   64'd0);
        chk("s6.b_valid", 64'(b_valid), 64'd0);
        chk("s6.a_count", 64'(a_count), 64'd0);
        chk("s6.a_valid", 64'(a_valid), 64'd0);
        model_reset();
        #1;
        reset = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("s6.restart", 64'(b_count), 64'd1);
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
